// File: rtl/coefficient_block_builder.sv
// Assembles one 8x8 block from a (run, coefficient) stream in zigzag order and streams it out in raster order.
// Optional build macro DC_PREDICT_EN: the DC strobe carries a difference that is added to a running predictor.
module coefficient_block_builder #(
    parameter int COEF_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        s_value,
    input  logic [COEF_W-1:0] coefficient,
    input  logic              is_new_coefficient,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [5:0]        out_index,
    output logic [COEF_W-1:0] out_coef,
    output logic              block_done,
    output logic              error
);

    typedef enum logic {
        FILL    = 1'b0,
        READOUT = 1'b1
    } state_t;

    // Zigzag scan position -> raster address (row*8+col).
    localparam logic [5:0] ZZ [64] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

    logic [COEF_W-1:0] mem [64];
    logic [COEF_W-1:0] rd_data_q;

    state_t            state_q, state_d;
    logic [6:0]        pos_q, pos_d;
    logic [5:0]        rd_q, rd_d;
    logic [63:0]       mask_q, mask_d;
    logic              rd_mask_q, rd_mask_d;
    logic              error_q, error_d;

    logic [6:0]        target;
    logic [6:0]        zrl_pos;
    logic [5:0]        rd_next;
    logic              accept;
    logic              handshake;
    logic              is_eob;
    logic              is_zrl;
    logic              complete;
    logic              wr_en;
    logic [5:0]        wr_addr;
    logic [COEF_W-1:0] wr_data;
    logic              rd_load;
    logic [5:0]        rd_addr;
    logic [COEF_W-1:0] dc_value;

`ifdef DC_PREDICT_EN
    logic [COEF_W-1:0] pred_q, pred_d;
    assign dc_value = pred_q + coefficient;
`else
    assign dc_value = coefficient;
`endif

    assign target    = pos_q + {3'b000, s_value};
    assign zrl_pos   = pos_q + 7'd16;
    assign rd_next   = rd_q + 6'd1;
    assign accept    = (state_q == FILL) && is_new_coefficient;
    assign handshake = (state_q == READOUT) && out_ready;
    assign is_eob    = (s_value == 4'd0) && (coefficient == '0);
    assign is_zrl    = (s_value == 4'd15) && (coefficient == '0);

    always_comb begin
        state_d   = state_q;
        pos_d     = pos_q;
        rd_d      = rd_q;
        mask_d    = mask_q;
        rd_mask_d = rd_mask_q;
        error_d   = error_q;
        complete  = 1'b0;
        wr_en     = 1'b0;
        wr_addr   = ZZ[target[5:0]];
        wr_data   = coefficient;
        rd_load   = 1'b0;
        rd_addr   = 6'd0;
`ifdef DC_PREDICT_EN
        pred_d    = pred_q;
`endif

        if (accept) begin
            if (pos_q == 7'd0) begin
                wr_en   = 1'b1;
                wr_addr = 6'd0;
                wr_data = dc_value;
                pos_d   = 7'd1;
`ifdef DC_PREDICT_EN
                pred_d  = dc_value;
`endif
            end else if (is_eob) begin
                complete = 1'b1;
            end else if (is_zrl) begin
                pos_d = zrl_pos;
                if (zrl_pos >= 7'd64) begin
                    complete = 1'b1;
                end
                if (zrl_pos > 7'd64) begin
                    error_d = 1'b1;
                end
            end else if (target <= 7'd63) begin
                wr_en = 1'b1;
                pos_d = target + 7'd1;
                if (target == 7'd63) begin
                    complete = 1'b1;
                end
            end else begin
                error_d  = 1'b1;
                complete = 1'b1;
            end
        end

        // A strobe outside FILL is dropped but flagged.
        if ((state_q == READOUT) && is_new_coefficient) begin
            error_d = 1'b1;
        end

        if (wr_en) begin
            mask_d[wr_addr] = 1'b1;
        end

        // Prefetch raster 0; the completing write never targets address 0.
        if (complete) begin
            state_d   = READOUT;
            rd_d      = 6'd0;
            rd_load   = 1'b1;
            rd_addr   = 6'd0;
            rd_mask_d = mask_q[0];
        end

        if (handshake) begin
            if (rd_q == 6'd63) begin
                state_d   = FILL;
                rd_d      = 6'd0;
                pos_d     = 7'd0;
                mask_d    = '0;
                rd_mask_d = 1'b0;
            end else begin
                rd_d      = rd_next;
                rd_load   = 1'b1;
                rd_addr   = rd_next;
                rd_mask_d = mask_q[rd_next];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= FILL;
            pos_q     <= 7'd0;
            rd_q      <= 6'd0;
            mask_q    <= '0;
            rd_mask_q <= 1'b0;
            error_q   <= 1'b0;
`ifdef DC_PREDICT_EN
            pred_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            pos_q     <= pos_d;
            rd_q      <= rd_d;
            mask_q    <= mask_d;
            rd_mask_q <= rd_mask_d;
            error_q   <= error_d;
`ifdef DC_PREDICT_EN
            pred_q    <= pred_d;
`endif
        end
    end

    // Storage has no reset; the written-mask decides what is visible.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_load) begin
            rd_data_q <= mem[rd_addr];
        end
    end

    assign in_ready   = (state_q == FILL);
    assign out_valid  = (state_q == READOUT);
    assign out_index  = rd_q;
    assign out_coef   = rd_mask_q ? rd_data_q : '0;
    assign block_done = handshake && (rd_q == 6'd63);
    assign error      = error_q;

endmodule

// File: tb/tb_coefficient_block_builder.sv
// Directed bench for coefficient_block_builder: table of block strobes plus hand-written
// sequences for throttled readout, dropped strobes and asynchronous reset.
module tb_coefficient_block_builder;

    localparam int COEF_W = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [3:0]        s_value;
    logic [COEF_W-1:0] coefficient;
    logic              is_new_coefficient;
    logic              in_ready;
    logic              out_valid;
    logic              out_ready;
    logic [5:0]        out_index;
    logic [COEF_W-1:0] out_coef;
    logic              block_done;
    logic              error;

    coefficient_block_builder #(.COEF_W(COEF_W)) dut (
        .clk                (clk),
        .rst                (rst),
        .s_value            (s_value),
        .coefficient        (coefficient),
        .is_new_coefficient (is_new_coefficient),
        .in_ready           (in_ready),
        .out_valid          (out_valid),
        .out_ready          (out_ready),
        .out_index          (out_index),
        .out_coef           (out_coef),
        .block_done         (block_done),
        .error              (error)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         blk;
        logic [3:0] s;
        int         c;
    } vec_t;

    typedef struct {
        int blk;
        int idx;
        int val;
    } nz_t;

    vec_t vecs[$];
    nz_t  nzs[$];
    int   exp_blk[64];
    int   checks = 0;
    int   errors = 0;

    // Expected stored DC per table block (predictor accumulates across blocks 0..4).
`ifdef DC_PREDICT_EN
    localparam int DC0 = 10, DC1 = 7, DC2 = 7, DC3 = 12, DC4 = 12;
`else
    localparam int DC0 = 10, DC1 = -3, DC2 = 0, DC3 = 5, DC4 = 0;
`endif

    int rst_before[6] = '{1, 0, 0, 0, 0, 1};
    int exp_err[6]    = '{0, 0, 0, 0, 0, 1};

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic addv(input int b, input int s, input int c);
        vecs.push_back('{b, 4'(s), c});
    endtask

    task automatic addnz(input int b, input int idx, input int val);
        nzs.push_back('{b, idx, val});
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic send(input int s, input int c);
        s_value            = 4'(s);
        coefficient        = COEF_W'(c);
        is_new_coefficient = 1'b1;
        @(posedge clk);
        #1;
        is_new_coefficient = 1'b0;
        $display("strobe run=%0d coef=%0d in_ready=%0b error=%0b", s, c, in_ready, error);
    endtask

    task automatic clear_exp();
        for (int i = 0; i < 64; i++) exp_blk[i] = 0;
    endtask

    // Drains one block; with throttle, out_ready is low on even cycles (128 cycles total).
    task automatic readout(input bit throttle, input bit poke, input string tag);
        int rd  = 0;
        int cyc = 0;
        while (rd < 64 && cyc < 400) begin
            out_ready = throttle ? ((cyc % 2) == 1) : 1'b1;
            if (poke && cyc == 5) begin
                s_value            = 4'd0;
                coefficient        = COEF_W'(55);
                is_new_coefficient = 1'b1;
            end
            #1;
            check($sformatf("%s.valid[%0d]", tag, rd), int'(out_valid), 1);
            check($sformatf("%s.index[%0d]", tag, rd), int'(out_index), rd);
            check($sformatf("%s.coef[%0d]", tag, rd), int'($signed(out_coef)), exp_blk[rd]);
            check($sformatf("%s.done[%0d]", tag, rd), int'(block_done), int'(out_ready && rd == 63));
            @(posedge clk);
            #1;
            is_new_coefficient = 1'b0;
            if (out_ready) rd++;
            cyc++;
        end
        out_ready = 1'b0;
        check($sformatf("%s.handshakes", tag), rd, 64);
        check($sformatf("%s.cycles", tag), cyc, throttle ? 128 : 64);
        check($sformatf("%s.in_ready_after", tag), int'(in_ready), 1);
        check($sformatf("%s.out_valid_after", tag), int'(out_valid), 0);
        $display("block %s read out in %0d cycles error=%0b", tag, cyc, error);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst                = 1'b1;
        s_value            = 4'd0;
        coefficient        = '0;
        is_new_coefficient = 1'b0;
        out_ready          = 1'b0;

        // Block 0..2: DC predictor sequence; 3: basic AC; 4: ZRL to zz63; 5: run overflow.
        addv(0, 0, 10); addv(0, 0, 0);
        addv(1, 0, -3); addv(1, 0, 0);
        addv(2, 0, 0);  addv(2, 0, 0);
        addv(3, 0, 5);  addv(3, 0, 3);  addv(3, 2, -1); addv(3, 0, 0);
        addv(4, 0, 0);  addv(4, 15, 0); addv(4, 15, 0); addv(4, 15, 0); addv(4, 14, 7);
        addv(5, 0, 1);  addv(5, 0, 2);  addv(5, 15, 0); addv(5, 15, 0); addv(5, 15, 0);
        addv(5, 15, 9);
        addnz(0, 0, DC0);
        addnz(1, 0, DC1);
        addnz(2, 0, DC2);
        addnz(3, 0, DC3); addnz(3, 1, 3); addnz(3, 9, -1);
        addnz(4, 0, DC4); addnz(4, 63, 7);
        addnz(5, 0, 1);   addnz(5, 1, 2);

        repeat (2) @(posedge clk);
        #1;
        check("rst.in_ready", int'(in_ready), 1);
        check("rst.out_valid", int'(out_valid), 0);
        check("rst.out_index", int'(out_index), 0);
        check("rst.out_coef", int'(out_coef), 0);
        check("rst.block_done", int'(block_done), 0);
        check("rst.error", int'(error), 0);
        rst = 1'b0;

        for (int b = 0; b < 6; b++) begin
            if (rst_before[b] != 0) do_reset();
            for (int i = 0; i < vecs.size(); i++) begin
                if (vecs[i].blk == b) begin
                    bit last;
                    last = (i == vecs.size() - 1) || (vecs[i+1].blk != b);
                    send(int'(vecs[i].s), vecs[i].c);
                    check($sformatf("blk%0d.in_ready[%0d]", b, i), int'(in_ready), last ? 0 : 1);
                    check($sformatf("blk%0d.out_valid[%0d]", b, i), int'(out_valid), last ? 1 : 0);
                end
            end
            clear_exp();
            for (int i = 0; i < nzs.size(); i++) begin
                if (nzs[i].blk == b) exp_blk[nzs[i].idx] = nzs[i].val;
            end
            readout(1'b0, 1'b0, $sformatf("blk%0d", b));
            check($sformatf("blk%0d.error", b), int'(error), exp_err[b]);
        end

        // Throttled readout with a strobe arriving mid-readout.
        do_reset();
        send(0, -2); send(1, 4); send(0, 0);
        clear_exp();
        exp_blk[0] = -2;
        exp_blk[8] = 4;
        readout(1'b1, 1'b1, "throttle");
        check("throttle.error", int'(error), 1);

        // Asynchronous reset part-way through a fill of 20 coefficients.
        do_reset();
        send(0, 9);
        for (int i = 1; i < 20; i++) send(0, i);
        check("midfill.in_ready", int'(in_ready), 1);
        #2;
        rst = 1'b1;
        #1;
        check("midfill_rst.in_ready", int'(in_ready), 1);
        check("midfill_rst.out_valid", int'(out_valid), 0);
        check("midfill_rst.error", int'(error), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        send(0, 4); send(0, 0);
        clear_exp();
        exp_blk[0] = 4;
        readout(1'b0, 1'b0, "after_fill_rst");

        // Asynchronous reset part-way through a readout.
        send(0, 6); send(0, 0);
        out_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("midread.out_index", int'(out_index), 10);
        #2;
        rst = 1'b1;
        #1;
        check("midread_rst.out_valid", int'(out_valid), 0);
        check("midread_rst.in_ready", int'(in_ready), 1);
        check("midread_rst.out_index", int'(out_index), 0);
        check("midread_rst.out_coef", int'(out_coef), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        send(0, -5); send(3, 8); send(0, 0);
        clear_exp();
        exp_blk[0] = -5;
        exp_blk[9] = 8;
        readout(1'b0, 1'b0, "after_read_rst");
        check("after_read_rst.error", int'(error), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
